// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RV32I MEM-stage load/store unit over a byte-enabled RAM, loads stall EX for RD_LAT cycles.
// Optional MEM_MISALIGN_TRAP_EN flags misaligned half/word accesses instead of aligning them down.
module mem_stage_lsu #(
    parameter int DEPTH_WORDS = 256,
    parameter int RD_LAT = 2,
    localparam int XLEN = 32,
    localparam int INSTR_WIDTH = 32,
    localparam int REG_IDX_WIDTH = 5,
    localparam int ADDR_W = $clog2(DEPTH_WORDS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ex_mem_valid_i,
    input  logic [INSTR_WIDTH-1:0]   ex_mem_instr_i,
    input  logic [XLEN-1:0]          ex_mem_rs2_rdata_i,
    input  logic [XLEN-1:0]          ex_mem_alu_res_i,
    output logic                     mem_ready_o,
    output logic                     mem_valid_o,
    output logic [REG_IDX_WIDTH-1:0] mem_rd_idx_o,
    output logic                     mem_rd_en_o,
    output logic [XLEN-1:0]          mem_rd_wdata_o,
    output logic                     mem_misalign_o
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] ld_idx_q, ld_idx_d;
    logic [1:0] ld_off_q, ld_off_d;
    logic [2:0] ld_f3_q, ld_f3_d;
    logic [REG_IDX_WIDTH-1:0] ld_rd_q, ld_rd_d, rd_idx_q, rd_idx_d;
    logic valid_q, valid_d, rd_en_q, rd_en_d, mis_q, mis_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] mem [DEPTH_WORDS];
    logic [6:0] opc;
    logic [2:0] f3;
    logic [REG_IDX_WIDTH-1:0] rd;
    logic [ADDR_W-1:0] idx;
    logic [1:0] a_lo, off;
    logic ld_ok, st_ok, trap, accept, do_ld, do_st;
    logic [3:0] be;
    logic [XLEN-1:0] st_data;
    logic unused_bits;

    assign opc = ex_mem_instr_i[6:0];
    assign rd = ex_mem_instr_i[11:7];
    assign f3 = ex_mem_instr_i[14:12];
    assign idx = ex_mem_alu_res_i[ADDR_W+1:2];
    assign a_lo = ex_mem_alu_res_i[1:0];
    assign unused_bits = ^{ex_mem_instr_i[INSTR_WIDTH-1:15], ex_mem_alu_res_i[XLEN-1:ADDR_W+2]};
    assign ld_ok = opc == 7'b0000011 && f3 != 3'b011 && f3[2:1] != 2'b11;
    assign st_ok = opc == 7'b0100011 && !f3[2] && f3[1:0] != 2'b11;
`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = (ld_ok || st_ok) && ((f3[1:0] == 2'b01 && a_lo[0]) || (f3[1:0] == 2'b10 && a_lo != 2'b00));
    assign off = a_lo;
`else
    assign trap = 1'b0;
    assign off = f3[1] ? 2'b00 : {a_lo[1], a_lo[0] & ~f3[0]};
`endif
    assign accept = ex_mem_valid_i && state_q == S_IDLE;
    assign do_ld = ld_ok && !trap;
    assign do_st = accept && st_ok && !trap;
    assign be = f3[1] ? 4'b1111 : f3[0] ? 4'b0011 << off : 4'b0001 << off;
    assign st_data = f3[1] ? ex_mem_rs2_rdata_i : f3[0] ? {2{ex_mem_rs2_rdata_i[15:0]}} : {4{ex_mem_rs2_rdata_i[7:0]}};

    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] w, input logic [1:0] o, input logic [2:0] f);
        logic [7:0] b;
        logic [15:0] h;
        b = 8'(w >> {o, 3'b000});
        h = 16'(w >> {o[1], 4'b0000});
        return f == 3'b000 ? {{24{b[7]}}, b} : f == 3'b100 ? {24'b0, b} :
               f == 3'b001 ? {{16{h[15]}}, h} : f == 3'b101 ? {16'b0, h} :
               f == 3'b010 ? w : '0;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        valid_d = 1'b0;
        rd_en_d = 1'b0;
        rd_idx_d = '0;
        wdata_d = '0;
        mis_d = 1'b0;
        ld_idx_d = accept ? idx : ld_idx_q;
        ld_off_d = accept ? off : ld_off_q;
        ld_f3_d = accept ? f3 : ld_f3_q;
        ld_rd_d = accept ? rd : ld_rd_q;
        if (state_q == S_WAIT) begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
                state_d = S_IDLE;
                valid_d = 1'b1;
                rd_en_d = 1'b1;
                rd_idx_d = ld_rd_q;
                wdata_d = extract(mem[ld_idx_q], ld_off_q, ld_f3_q);
            end
        end else if (ex_mem_valid_i) begin
            if (do_ld && RD_LAT > 1) begin
                state_d = S_WAIT;
                cnt_d = 2'(RD_LAT - 1);
            end else begin
                valid_d = 1'b1;
                rd_en_d = do_ld;
                rd_idx_d = rd;
                mis_d = trap;
                wdata_d = do_ld ? extract(mem[idx], off, f3) : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            ld_idx_q <= '0;
            ld_off_q <= '0;
            ld_f3_q <= '0;
            ld_rd_q <= '0;
            valid_q <= 1'b0;
            rd_en_q <= 1'b0;
            rd_idx_q <= '0;
            wdata_q <= '0;
            mis_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            ld_idx_q <= ld_idx_d;
            ld_off_q <= ld_off_d;
            ld_f3_q <= ld_f3_d;
            ld_rd_q <= ld_rd_d;
            valid_q <= valid_d;
            rd_en_q <= rd_en_d;
            rd_idx_q <= rd_idx_d;
            wdata_q <= wdata_d;
            mis_q <= mis_d;
        end
    end

    // RAM contents survive reset, so the array has no reset branch
    always_ff @(posedge clk) begin
        if (do_st)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
    end

    assign mem_ready_o = state_q == S_IDLE;
    assign mem_valid_o = valid_q;
    assign mem_rd_idx_o = rd_idx_q;
    assign mem_rd_en_o = rd_en_q;
    assign mem_rd_wdata_o = wdata_q;
    assign mem_misalign_o = mis_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: scoreboard bench for mem_stage_lsu against a byte-array reference model.
module tb_mem_stage_lsu;
    localparam int DEPTH = 256;
    localparam int RD_LAT = 2;
    localparam int NB = DEPTH * 4;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    logic clk = 1'b0, rst_n = 1'b0, v = 1'b0;
    logic [31:0] instr = '0, rs2 = '0, alu = '0;
    logic ready, valid, rd_en, mis;
    logic [4:0] rd_idx;
    logic [31:0] wdata;

    mem_stage_lsu #(.DEPTH_WORDS(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .ex_mem_valid_i(v), .ex_mem_instr_i(instr),
        .ex_mem_rs2_rdata_i(rs2), .ex_mem_alu_res_i(alu), .mem_ready_o(ready),
        .mem_valid_o(valid), .mem_rd_idx_o(rd_idx), .mem_rd_en_o(rd_en),
        .mem_rd_wdata_o(wdata), .mem_misalign_o(mis)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0] rd;
        logic en;
        logic [31:0] data;
        logic mis;
        int at;
    } exp_t;
    exp_t q[$];
    logic [7:0] mdl [NB];
    int n_chk = 0, n_fail = 0, last_acc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("retire_cycle", cyc, e.at);
                chk("rd_idx", {27'b0, rd_idx}, {27'b0, e.rd});
                chk("rd_en", {31'b0, rd_en}, {31'b0, e.en});
                chk("rd_wdata", wdata, e.data);
                chk("misalign", {31'b0, mis}, {31'b0, e.mis});
            end
        end
    end

    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] d, input bit has, input logic [31:0] want);
        exp_t e;
        int g, ea, sz;
        logic [31:0] val;
        bit ld, st, misal;
        g = 0;
        @(negedge clk);
        instr = $urandom();
        instr[14:0] = {f3, rd, opc};
        rs2 = d;
        alu = a;
        v = 1'b1;
        while (!ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g == 20) begin
            chk("ready_timeout", 32'd0, 32'd1);
            v = 1'b0;
            return;
        end
        ld = opc == LD && (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        st = opc == ST && f3 < 3;
        sz = 1 << f3[1:0];
        ea = int'(a % NB);
        misal = (ld || st) && (ea % sz != 0);
        e.rd = rd;
        e.en = 1'b0;
        e.data = '0;
        e.mis = 1'b0;
        e.at = cyc + 1;
`ifdef MEM_MISALIGN_TRAP_EN
        if (misal) begin
            e.mis = 1'b1;
            ld = 0;
            st = 0;
        end
`else
        if (misal) ea -= ea % sz;
`endif
        if (st) for (int i = 0; i < sz; i++) mdl[ea+i] = d[8*i +: 8];
        if (ld) begin
            val = '0;
            for (int i = 0; i < sz; i++) val |= 32'(mdl[ea+i]) << (8 * i);
            if (!f3[2] && sz < 4 && val[8*sz-1]) val |= ~((32'd1 << (8 * sz)) - 1);
            e.en = 1'b1;
            e.data = has ? want : val;
            e.at = cyc + RD_LAT;
        end
        last_acc = cyc;
        q.push_back(e);
        @(posedge clk);
        #1 v = 1'b0;
    endtask

    task automatic st_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        issue(ST, f3, 5'($urandom), a, d, 1'b0, '0);
    endtask

    task automatic ld_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] want);
        issue(LD, f3, 5'($urandom), a, '0, 1'b1, want);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() != 0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("drain", q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        int prev;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_rd_en", {31'b0, rd_en}, 32'd0);
        chk("rst_rd_idx", {27'b0, rd_idx}, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_misalign", {31'b0, mis}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        st_op(3'b010, 32'h10, 32'h8765_4321);
        ld_op(3'b010, 32'h10, 32'h8765_4321);
        @(negedge clk);
        chk("ready_stall", {31'b0, ready}, RD_LAT > 1 ? 32'd0 : 32'd1);
        st_op(3'b010, 32'h10, 32'h0);
        st_op(3'b000, 32'h11, 32'hFF);
        ld_op(3'b010, 32'h10, 32'h0000_FF00);
        ld_op(3'b000, 32'h11, 32'hFFFF_FFFF);
        ld_op(3'b100, 32'h11, 32'h0000_00FF);
        st_op(3'b001, 32'h22, 32'h8001);
        ld_op(3'b001, 32'h22, 32'hFFFF_8001);
        ld_op(3'b101, 32'h422, 32'h0000_8001);
        for (int i = 0; i < 4; i++) st_op(3'b010, 32'h30 + 4 * i, 32'hC0DE_0000 + i);
        ld_op(3'b010, 32'h30, 32'hC0DE_0000);
        prev = last_acc;
        for (int i = 1; i < 4; i++) begin
            ld_op(3'b010, 32'h30 + 4 * i, 32'hC0DE_0000 + i);
            chk("b2b_spacing", last_acc - prev, RD_LAT);
            prev = last_acc;
        end
        issue(LD, 3'b010, 5'd0, 32'h10, '0, 1'b1, 32'h0000_FF00);
        issue(7'b0110011, 3'b000, 5'd7, 32'h10, 32'h1234_5678, 1'b0, '0);
        issue(LD, 3'b011, 5'd9, 32'h10, '0, 1'b0, '0);
        issue(ST, 3'b100, 5'd3, 32'h10, 32'h1234_5678, 1'b0, '0);
        ld_op(3'b010, 32'h10, 32'h0000_FF00);
        st_op(3'b010, 32'h13, 32'hAABB_CCDD);
`ifdef MEM_MISALIGN_TRAP_EN
        ld_op(3'b010, 32'h10, 32'h0000_FF00);
`else
        ld_op(3'b010, 32'h10, 32'hAABB_CCDD);
`endif
        drain();
        st_op(3'b010, 32'h40, 32'h5A5A_1234);
        ld_op(3'b010, 32'h40, 32'h5A5A_1234);
        @(negedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        #1 chk("midload_rst_ready", {31'b0, ready}, 32'd1);
        chk("midload_rst_valid", {31'b0, valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (RD_LAT + 2) @(negedge clk);
        chk("post_rst_ready", {31'b0, ready}, 32'd1);
        ld_op(3'b010, 32'h40, 32'h5A5A_1234);
        for (int i = 0; i < 16; i++) st_op(3'b010, 32'(4 * i), $urandom());
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            issue(r < 4 ? LD : r < 8 ? ST : 7'b0010011, 3'($urandom), 5'($urandom),
                  ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 63)), $urandom(), 1'b0, '0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
